net_change_sink: RTL and testbench

- Consumer stage directly downstream of the simulator output FIFO.
- Pops 32-bit net-change records {value[31:30], net_index[29:16], sim_time[15:0]} and keeps a per-net current-value table.
- Presents each change to the waveform/checker side as a valid/ready event carrying both the old and the new value.
- Flags sim_time ordering violations and out-of-range net indices.

---
 rtl/net_sim_pkg.sv | 26 ++
 rtl/net_value_table.sv | 41 ++++
 rtl/net_change_sink.sv | 215 +++++++++++++++++++++
 tb/tb_net_change_sink.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_sim_pkg.sv
// Shared constants and record layout for the net-change sink.
package net_sim_pkg;

  localparam logic [1:0] VAL_0 = 2'd0;
  localparam logic [1:0] VAL_1 = 2'd1;
  localparam logic [1:0] VAL_X = 2'd2;
  localparam logic [1:0] VAL_Z = 2'd3;

  localparam int VAL_MSB  = 31;
  localparam int IDX_MSB  = 29;
  localparam int IDX_LSB  = 16;
  localparam int TIME_MSB = 15;

  localparam logic [2:0] CLEAR = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] EVAL  = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;

  typedef struct packed {
    logic [VAL_MSB-IDX_MSB-1:0] val;
    logic [IDX_MSB-IDX_LSB:0]   idx;
    logic [TIME_MSB:0]          stamp;
  } rec_t;

endpackage

// File: rtl/net_value_table.sv
// Per-net 2-bit current-value store; combinational read,
// synchronous write, no reset (initialised by the CLEAR walk).
import net_sim_pkg::*;

module net_value_table #(
  parameter int NETS   = 256,
  parameter int IDX_WD = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_WD-1:0] wr_addr,
  input  logic [1:0]        wr_data,
  input  logic [IDX_WD-1:0] rd_addr,
  output logic [1:0]        rd_data
);

  localparam logic [31:0] NETS_U = NETS;

  logic [1:0] mem_q [NETS];
  logic       wr_ok;
  logic       rd_ok;

  always_comb begin
    wr_ok = ({{(32-IDX_WD){1'b0}}, wr_addr} < NETS_U);
    rd_ok = ({{(32-IDX_WD){1'b0}}, rd_addr} < NETS_U);
  end

  always_ff @(posedge clk) begin
    if (we && wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = VAL_X;
    if (rd_ok) begin
      rd_data = mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/net_change_sink.sv
// FIFO consumer turning net-change records into old/new events.
// NET_CHANGE_SINK_DEDUP_EN drops same-value records, adds dup_count.
import net_sim_pkg::*;

module net_change_sink #(
  parameter int NETS   = 256,
  parameter int IDX_WD = 8,
  parameter int CNT_WD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [31:0]       fifo_rd_data,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [13:0]       evt_net,
  output logic [1:0]        evt_old,
  output logic [1:0]        evt_new,
  output logic [15:0]       evt_time,
  output logic [CNT_WD-1:0] evt_count,
  output logic              time_err,
  output logic              idx_err,
`ifdef NET_CHANGE_SINK_DEDUP_EN
  output logic [15:0]       dup_count,
`endif
  output logic              busy
);

  localparam logic [31:0] NETS_U = NETS;
  localparam logic [IDX_WD-1:0] PTR_LAST = IDX_WD'(NETS - 1);

  logic [2:0]        state_q, state_d;
  logic [IDX_WD-1:0] ptr_q, ptr_d;
  rec_t              rec_q, rec_d;
  logic              evt_valid_q, evt_valid_d;
  logic [13:0]       evt_net_q, evt_net_d;
  logic [1:0]        evt_old_q, evt_old_d;
  logic [1:0]        evt_new_q, evt_new_d;
  logic [15:0]       evt_time_q, evt_time_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;
  logic              time_err_q, time_err_d;
  logic              idx_err_q, idx_err_d;
  logic [15:0]       last_time_q, last_time_d;
`ifdef NET_CHANGE_SINK_DEDUP_EN
  logic [15:0]       dup_q, dup_d;
`endif

  logic              tbl_we;
  logic [IDX_WD-1:0] tbl_waddr;
  logic [1:0]        tbl_wdata;
  logic [IDX_WD-1:0] rd_addr;
  logic [1:0]        tbl_rdata;
  logic              idx_oob;

  assign rd_addr = rec_q.idx[IDX_WD-1:0];
  assign idx_oob = ({18'd0, rec_q.idx} >= NETS_U);

  net_value_table #(
    .NETS   (NETS),
    .IDX_WD (IDX_WD)
  ) u_table (
    .clk     (clk),
    .we      (tbl_we),
    .wr_addr (tbl_waddr),
    .wr_data (tbl_wdata),
    .rd_addr (rd_addr),
    .rd_data (tbl_rdata)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rec_d       = rec_q;
    evt_valid_d = evt_valid_q;
    evt_net_d   = evt_net_q;
    evt_old_d   = evt_old_q;
    evt_new_d   = evt_new_q;
    evt_time_d  = evt_time_q;
    cnt_d       = cnt_q;
    time_err_d  = time_err_q;
    idx_err_d   = idx_err_q;
    last_time_d = last_time_q;
`ifdef NET_CHANGE_SINK_DEDUP_EN
    dup_d       = dup_q;
`endif
    fifo_rd     = 1'b0;
    tbl_we      = 1'b0;
    tbl_waddr   = rd_addr;
    tbl_wdata   = evt_new_q;
    unique case (1'b1)
      (state_q == CLEAR): begin
        tbl_we      = 1'b1;
        tbl_waddr   = ptr_q;
        tbl_wdata   = VAL_X;
        cnt_d       = '0;
        last_time_d = '0;
`ifdef NET_CHANGE_SINK_DEDUP_EN
        dup_d       = '0;
`endif
        ptr_d       = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          ptr_d   = '0;
          state_d = IDLE;
        end
      end
      (state_q == IDLE): begin
        if (clear) begin
          ptr_d   = '0;
          state_d = CLEAR;
        end else if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = WAIT;
        end
      end
      (state_q == WAIT): begin
        rec_d   = rec_t'(fifo_rd_data);
        state_d = EVAL;
      end
      (state_q == EVAL): begin
        if (idx_oob) begin
          idx_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          if (rec_q.stamp < last_time_q) begin
            time_err_d = 1'b1;
          end
`ifdef NET_CHANGE_SINK_DEDUP_EN
          if (tbl_rdata == rec_q.val) begin
            last_time_d = rec_q.stamp;
            if (dup_q != '1) begin
              dup_d = dup_q + 16'd1;
            end
            state_d = IDLE;
          end else
`endif
          begin
            evt_net_d   = rec_q.idx;
            evt_old_d   = tbl_rdata;
            evt_new_d   = rec_q.val;
            evt_time_d  = rec_q.stamp;
            evt_valid_d = 1'b1;
            state_d     = EMIT;
          end
        end
      end
      (state_q == EMIT): begin
        if (evt_ready) begin
          tbl_we      = 1'b1;
          last_time_d = evt_time_q;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WD'(1);
          end
          evt_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      rec_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_net_q   <= '0;
      evt_old_q   <= '0;
      evt_new_q   <= '0;
      evt_time_q  <= '0;
      cnt_q       <= '0;
      time_err_q  <= 1'b0;
      idx_err_q   <= 1'b0;
      last_time_q <= '0;
`ifdef NET_CHANGE_SINK_DEDUP_EN
      dup_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rec_q       <= rec_d;
      evt_valid_q <= evt_valid_d;
      evt_net_q   <= evt_net_d;
      evt_old_q   <= evt_old_d;
      evt_new_q   <= evt_new_d;
      evt_time_q  <= evt_time_d;
      cnt_q       <= cnt_d;
      time_err_q  <= time_err_d;
      idx_err_q   <= idx_err_d;
      last_time_q <= last_time_d;
`ifdef NET_CHANGE_SINK_DEDUP_EN
      dup_q       <= dup_d;
`endif
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_net   = evt_net_q;
  assign evt_old   = evt_old_q;
  assign evt_new   = evt_new_q;
  assign evt_time  = evt_time_q;
  assign evt_count = cnt_q;
  assign time_err  = time_err_q;
  assign idx_err   = idx_err_q;
  assign busy      = (state_q != IDLE);
`ifdef NET_CHANGE_SINK_DEDUP_EN
  assign dup_count = dup_q;
`endif

endmodule

// File: tb/tb_net_change_sink.sv
// Bench for net_change_sink: vectors, corner sequences, random vs model.
module tb_net_change_sink;

  localparam int NETS = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic [31:0] fifo_rd_data = '0;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [13:0] evt_net;
  logic [1:0]  evt_old;
  logic [1:0]  evt_new;
  logic [15:0] evt_time;
  logic [15:0] evt_count;
  logic        time_err;
  logic        idx_err;
  logic        busy;
`ifdef NET_CHANGE_SINK_DEDUP_EN
  logic [15:0] dup_count;
`endif

  net_change_sink #(.NETS(NETS), .IDX_WD(8), .CNT_WD(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .fifo_empty   (fifo_empty),
    .fifo_rd      (fifo_rd),
    .fifo_rd_data (fifo_rd_data),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_net      (evt_net),
    .evt_old      (evt_old),
    .evt_new      (evt_new),
    .evt_time     (evt_time),
    .evt_count    (evt_count),
    .time_err     (time_err),
    .idx_err      (idx_err),
`ifdef NET_CHANGE_SINK_DEDUP_EN
    .dup_count    (dup_count),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [13:0] net;
    logic [1:0]  o;
    logic [1:0]  n;
    logic [15:0] t;
    logic [15:0] c;
  } ev_t;

  // Reference model: a plain array of values plus ordered expectations.
  logic [1:0]  m_tab [NETS];
  logic [15:0] m_last, m_cnt, m_dup;
  bit          m_terr, m_ierr;
  ev_t         exp_q[$];
  ev_t         ev_log[$];
  logic [31:0] fq[$];
  bit          pend = 0;
  int          cyc = 0;
  int          rd_cyc[$];

  function automatic void m_clear();
    foreach (m_tab[i]) m_tab[i] = 2'd2;
    m_cnt  = 0;
    m_last = 0;
    m_dup  = 0;
  endfunction

  task automatic push(input logic [31:0] r);
    logic [1:0]  v;
    logic [13:0] ix;
    logic [15:0] t;
    v  = r[31:30];
    ix = r[29:16];
    t  = r[15:0];
    if (int'(ix) >= NETS) begin
      m_ierr = 1;
    end else begin
      if (t < m_last) m_terr = 1;
`ifdef NET_CHANGE_SINK_DEDUP_EN
      if (m_tab[ix] == v) begin
        m_last = t;
        if (m_dup != 16'hffff) m_dup++;
      end else
`endif
      begin
        exp_q.push_back('{ix, m_tab[ix], v, t, m_cnt});
        m_tab[ix] = v;
        m_last = t;
        if (m_cnt != 16'hffff) m_cnt++;
      end
    end
    fq.push_back(r);
    fifo_empty = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Upstream FIFO: data appears the cycle after the pop strobe.
  always @(negedge clk) begin
    if (pend && fq.size() > 0) begin
      fifo_rd_data = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
    pend = fifo_rd;
    if (fifo_rd) begin
      rd_cyc.push_back(cyc);
      chk("rd_while_empty", fifo_empty, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      ev_t a;
      a = '{evt_net, evt_old, evt_new, evt_time, evt_count};
      ev_log.push_back(a);
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_event: got %0h expected none", a);
      end else begin
        chk("event", a, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while ((!fifo_empty || busy || pend) && n < 400) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < 400, 1'b1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!evt_valid && n < 100) begin
      tick();
      n++;
    end
    chk("valid_timeout", evt_valid, 1'b1);
  endtask

  task automatic walk(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (busy && cycles < 1000);
  endtask

  typedef struct {
    logic [31:0] rec;
    bit          ev;
    logic [1:0]  o;
    logic [1:0]  n;
    bit          te;
    bit          ie;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   cy, n0, n, pushed;
    ev_t  cap;
    logic [15:0] tc;
    logic [15:0] tt;
    logic [13:0] ix;

    vecs[0] = '{32'h412C_0078, 0, 0, 0, 0, 1, 5};
    vecs[1] = '{32'h000A_005A, 1, 2, 0, 1, 1, 6};
    vecs[2] = '{32'hC00A_00C8, 1, 0, 3, 1, 1, 7};
    vecs[3] = '{32'h40FF_00C9, 1, 2, 1, 1, 1, 8};
    vecs[4] = '{32'h0100_00CA, 0, 0, 0, 1, 1, 8};
    vecs[5] = '{32'hBFFF_00CB, 0, 0, 0, 1, 1, 8};
    vecs[6] = '{32'h4000_00CB, 1, 2, 1, 1, 1, 9};

    m_clear();
    m_terr = 0;
    m_ierr = 0;
    repeat (3) tick();
    chk("rst_busy", busy, 1'b1);
    chk("rst_fifo_rd", fifo_rd, 1'b0);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_data", {evt_net, evt_old, evt_new, evt_time}, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_errs", {time_err, idx_err}, 0);
`ifdef NET_CHANGE_SINK_DEDUP_EN
    chk("rst_dup", dup_count, 0);
`endif
    rst = 1'b1;
    walk(cy);
    chk("clear_len_reset", cy, NETS);

    // Back-to-back records for net 50.
    rd_cyc.delete();
    ev_log.delete();
    push(32'h4032_0064);
    push(32'h0032_0069);
    push(32'h4032_006E);
    wait_idle();
    chk("b2b_nrd", rd_cyc.size(), 3);
    if (rd_cyc.size() == 3) begin
      chk("b2b_gap0", rd_cyc[1] - rd_cyc[0], 4);
      chk("b2b_gap1", rd_cyc[2] - rd_cyc[1], 4);
    end
    chk("b2b_nev", ev_log.size(), 3);
    if (ev_log.size() == 3) begin
      chk("b2b_ev0", {ev_log[0].o, ev_log[0].n, ev_log[0].t}, {4'h9, 16'd100});
      chk("b2b_ev1", {ev_log[1].o, ev_log[1].n}, 4'h4);
      chk("b2b_ev2", {ev_log[2].o, ev_log[2].n}, 4'h1);
    end
    chk("b2b_count", evt_count, 3);
    chk("b2b_terr", time_err, 1'b0);

    // Backpressure on the consumer side.
    evt_ready = 1'b0;
    push(32'h8032_0073);
    push(32'h4032_0078);
    wait_valid();
    cap = '{evt_net, evt_old, evt_new, evt_time, evt_count};
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_stable", {evt_valid, evt_net, evt_old, evt_new, evt_time},
          {1'b1, cap.net, cap.o, cap.n, cap.t});
      chk("bp_no_rd", fifo_rd, 1'b0);
    end
    chk("bp_hold_count", evt_count, 3);
    evt_ready = 1'b1;
    wait_idle();
    chk("bp_second", {ev_log[$].o, ev_log[$].n, ev_log[$].t}, {4'h9, 16'd120});
    chk("bp_count", evt_count, 5);

    foreach (vecs[i]) begin
      n0 = ev_log.size();
      push(vecs[i].rec);
      wait_idle();
      chk($sformatf("vec%0d_nev", i), ev_log.size() - n0, vecs[i].ev);
      if (vecs[i].ev && ev_log.size() > n0) begin
        chk($sformatf("vec%0d_on", i), {ev_log[$].o, ev_log[$].n},
            {vecs[i].o, vecs[i].n});
        chk($sformatf("vec%0d_t", i), ev_log[$].t, vecs[i].rec[15:0]);
      end
      chk($sformatf("vec%0d_errs", i), {time_err, idx_err},
          {vecs[i].te, vecs[i].ie});
      chk($sformatf("vec%0d_cnt", i), evt_count, vecs[i].cnt);
    end

    // Clear pulse from IDLE.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_clear();
    walk(cy);
    chk("clear_len", cy, NETS);
    chk("clear_count", evt_count, 0);
    chk("clear_errs_kept", {time_err, idx_err}, 2'b11);

    n0 = ev_log.size();
    push(32'hC007_0001);
    push(32'hC007_0002);
    wait_idle();
`ifdef NET_CHANGE_SINK_DEDUP_EN
    chk("dedup_nev", ev_log.size() - n0, 1);
    chk("dedup_dup", dup_count, 1);
    chk("dedup_cnt", evt_count, 1);
`else
    chk("nodedup_nev", ev_log.size() - n0, 2);
    chk("nodedup_on", {ev_log[$].o, ev_log[$].n}, 4'hF);
    chk("nodedup_cnt", evt_count, 2);
`endif
    push(32'h4032_0005);
    wait_idle();
    chk("post_clear_old", {ev_log[$].net, ev_log[$].o, ev_log[$].n},
        {14'd50, 2'd2, 2'd1});

    // Reset while an event is stalled.
    evt_ready = 1'b0;
    push(32'h4005_0010);
    wait_valid();
    rst = 1'b0;
    #1;
    chk("mid_rst_outs", {evt_valid, fifo_rd, busy, time_err, idx_err}, 5'b00100);
    chk("mid_rst_data", {evt_net, evt_time, evt_count}, 0);
    exp_q.delete();
    fq.delete();
    pend = 0;
    fifo_empty = 1'b1;
    m_clear();
    m_terr = 0;
    m_ierr = 0;
    evt_ready = 1'b1;
    tick();
    rst = 1'b1;
    walk(cy);
    chk("clear_len_mid_rst", cy, NETS);

    // Random traffic against the model.
    tc = 16'd1000;
    pushed = 0;
    n = 0;
    while (pushed < 300 && n < 20000) begin
      if (fq.size() < 2) begin
        if ($urandom_range(0, 99) < 8) ix = 14'($urandom_range(256, 16383));
        else if ($urandom_range(0, 1) == 0) ix = 14'($urandom_range(0, 7));
        else ix = 14'($urandom_range(240, 255));
        tc = tc + 16'($urandom_range(0, 5));
        tt = tc;
        if ($urandom_range(0, 9) == 0) tt = tc - 16'($urandom_range(1, 10));
        push({2'($urandom_range(0, 3)), ix, tt});
        pushed++;
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    evt_ready = 1'b1;
    wait_idle();
    chk("rand_pending", exp_q.size(), 0);
    chk("rand_count", evt_count, m_cnt);
    chk("rand_errs", {time_err, idx_err}, {m_terr, m_ierr});
`ifdef NET_CHANGE_SINK_DEDUP_EN
    chk("rand_dup", dup_count, m_dup);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
